// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared constants and entry flattening for the RO-stage scoreboard
//   No ports. Provides register-file codes, common register indices, the
//   scoreboard entry count, and entry_of() which maps {file,idx} to 0..24.
package ro_pkg;

   localparam logic [1:0] FILE_GPR = 2'b00;
   localparam logic [1:0] FILE_MM  = 2'b01;
   localparam logic [1:0] FILE_SEG = 2'b10;
   localparam logic [1:0] FILE_ZF  = 2'b11;

   localparam logic [2:0] REG_EAX  = 3'd0;
   localparam logic [2:0] REG_ECX  = 3'd1;

   localparam int NUM_ENT   = 25;
   localparam int ENT_W     = 5;
   localparam int ENT_IDX_W = 3;

   // GPR/MM/SEG occupy 0-7/8-15/16-23, so {file,idx} is already the entry
   // number; ZF has a single entry (24) and its index is ignored.
   function automatic logic [ENT_W-1:0] entry_of(input logic [1:0]           file,
                                                 input logic [ENT_IDX_W-1:0] idx);
      if (file == FILE_ZF)
         entry_of = 5'd24;
      else
         entry_of = {file, idx};
   endfunction

endpackage

// File: rtl/sb_entry_ctr.sv
// rtl/sb_entry_ctr.sv - one pending-write counter of the RO scoreboard
//   clk, rst   clock, synchronous active-high reset
//   flush      clears the counter, overriding inc/dec
//   inc        writes issued this cycle that target this entry
//   dec        retires this cycle that target this entry
//   req        writes requested this cycle (issued or not), for the sat check
//   count      current number of writes in flight
//   sat        count + req would exceed the counter maximum
module sb_entry_ctr #(
   parameter int CNT_W = 2,
   parameter int IN_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [IN_W-1:0]  inc,
   input  logic [IN_W-1:0]  dec,
   input  logic [IN_W-1:0]  req,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam int SUM_W = ((CNT_W > IN_W) ? CNT_W : IN_W) + 1;
   localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

   logic [SUM_W-1:0] up;
   logic [SUM_W-1:0] dn;
   logic [SUM_W-1:0] diff;
   logic [CNT_W-1:0] count_nxt;

   assign up   = SUM_W'(count) + SUM_W'(inc);
   assign dn   = SUM_W'(dec);
   assign diff = up - dn;
   assign sat  = (SUM_W'(count) + SUM_W'(req)) > MAX_CNT;

   // Issue and retire net out in one adder; underflow sticks at zero and an
   // overshoot (only possible if the sat stall were bypassed) holds at max.
   always_comb begin
      count_nxt = count;
      if (dn > up)
         count_nxt = '0;
      else if (diff > MAX_CNT)
         count_nxt = MAX_CNT[CNT_W-1:0];
      else
         count_nxt = diff[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst || flush)
         count <= '0;
      else
         count <= count_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush)
         assert (dn <= up) else $error("sb_entry_ctr: retire on an empty counter");
   end

endmodule

// File: rtl/ro_scoreboard_dep.sv
// rtl/ro_scoreboard_dep.sv - RO-stage read-operand dependency scoreboard
//   clk, rst                       clock, synchronous active-high reset
//   V_ro, eip_change               RO instruction valid, instruction redirects EIP
//   src_needed/src_file/src_idx    source operand slots to check
//   dst_ld/dst_file/dst_idx        destination slots written by the instruction
//   ret_v/ret_file/ret_idx         WB retire ports
//   ex_dep_stall, wb_mem_stall     downstream stalls (form stall_ro)
//   mem_rd_busy, cmps_stall        local RO stalls that gate V_ex
//   flush                          clears all pending counts
//   v_ro_ld, dep_stall, br_stall, stall_ro, ld_ex, V_ex   stage controls
//   pend_gpr                       per-GPR pending-write flag
//   dep_stall_cnt                  saturating count of dep_stall cycles
module ro_scoreboard_dep
   import ro_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int NUM_DST = 3,
   parameter int IDX_W   = 3,
   parameter int CNT_W   = 2,
   parameter int RET_BYP = 1,
   parameter int PERF_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     V_ro,
   input  logic                     eip_change,
   input  logic [NUM_SRC-1:0]       src_needed,
   input  logic [2*NUM_SRC-1:0]     src_file,
   input  logic [IDX_W*NUM_SRC-1:0] src_idx,
   input  logic [NUM_DST-1:0]       dst_ld,
   input  logic [2*NUM_DST-1:0]     dst_file,
   input  logic [IDX_W*NUM_DST-1:0] dst_idx,
   input  logic [NUM_DST-1:0]       ret_v,
   input  logic [2*NUM_DST-1:0]     ret_file,
   input  logic [IDX_W*NUM_DST-1:0] ret_idx,
   input  logic                     ex_dep_stall,
   input  logic                     wb_mem_stall,
   input  logic                     mem_rd_busy,
   input  logic                     cmps_stall,
   input  logic                     flush,
   output logic [NUM_DST-1:0]       v_ro_ld,
   output logic                     dep_stall,
   output logic                     br_stall,
   output logic                     stall_ro,
   output logic                     ld_ex,
   output logic                     V_ex,
   output logic [7:0]               pend_gpr,
   output logic [PERF_W-1:0]        dep_stall_cnt
);

   localparam int IN_W = $clog2(NUM_DST + 1);

   logic [ENT_W-1:0] src_ent [NUM_SRC];
   logic [ENT_W-1:0] dst_ent [NUM_DST];
   logic [ENT_W-1:0] ret_ent [NUM_DST];

   logic [IN_W-1:0]  req [NUM_ENT];
   logic [IN_W-1:0]  inc [NUM_ENT];
   logic [IN_W-1:0]  dec [NUM_ENT];
   logic [CNT_W-1:0] cnt [NUM_ENT];
   logic [NUM_ENT-1:0] sat;

   logic raw_hz;
   logic sat_hz;
   logic issue;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign src_ent[s] = entry_of(src_file[2*s +: 2], src_idx[IDX_W*s +: IDX_W]);
   end

   for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
      assign dst_ent[d] = entry_of(dst_file[2*d +: 2], dst_idx[IDX_W*d +: IDX_W]);
      assign ret_ent[d] = entry_of(ret_file[2*d +: 2], ret_idx[IDX_W*d +: IDX_W]);
   end

   // req counts every dst_ld hit regardless of issue, so the saturation check
   // never depends on V_ex (which itself depends on dep_stall).
   always_comb begin
      for (int e = 0; e < NUM_ENT; e++) begin
         req[e] = '0;
         dec[e] = '0;
         for (int d = 0; d < NUM_DST; d++) begin
            if (dst_ld[d] && dst_ent[d] == ENT_W'(e))
               req[e] = req[e] + IN_W'(1);
            if (ret_v[d] && ret_ent[d] == ENT_W'(e))
               dec[e] = dec[e] + IN_W'(1);
         end
      end
   end

   for (genvar e = 0; e < NUM_ENT; e++) begin : g_ent
      assign inc[e] = issue ? req[e] : '0;

      sb_entry_ctr #(
         .CNT_W (CNT_W),
         .IN_W  (IN_W)
      ) u_ctr (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .inc   (inc[e]),
         .dec   (dec[e]),
         .req   (req[e]),
         .count (cnt[e]),
         .sat   (sat[e])
      );
   end

   // A single outstanding write that retires this cycle is forwarded by WB,
   // so with RET_BYP it is not treated as a hazard.
   always_comb begin
      raw_hz = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (src_needed[s] && cnt[src_ent[s]] != '0) begin
            if (!(RET_BYP != 0 && cnt[src_ent[s]] == CNT_W'(1) && dec[src_ent[s]] != '0))
               raw_hz = 1'b1;
         end
      end
   end

   always_comb begin
      sat_hz = 1'b0;
      for (int d = 0; d < NUM_DST; d++) begin
         if (dst_ld[d] && sat[dst_ent[d]])
            sat_hz = 1'b1;
      end
   end

   assign dep_stall = V_ro & (raw_hz | sat_hz);
   assign br_stall  = V_ro & eip_change;
   assign stall_ro  = ex_dep_stall | wb_mem_stall;
   assign ld_ex     = ~stall_ro;
   assign V_ex      = V_ro & ~(dep_stall | cmps_stall | mem_rd_busy) & ~flush;
   assign issue     = V_ex & ld_ex;
   assign v_ro_ld   = dst_ld & {NUM_DST{V_ro}};

   for (genvar g = 0; g < 8; g++) begin : g_pend
      assign pend_gpr[g] = (cnt[g] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst)
         dep_stall_cnt <= '0;
      else if (dep_stall && dep_stall_cnt != {PERF_W{1'b1}})
         dep_stall_cnt <= dep_stall_cnt + PERF_W'(1);
   end

endmodule
